// File: rtl/rgb_temp_ramp.sv
// Colour-temperature shifter: a signed level (cool <-> warm) that moves at frame starts,
// applied to the pixel stream through a fixed 2-stage saturating offset pipeline.
module rgb_temp_ramp #(
  parameter int DW     = 8,
  parameter int LEVELS = 4,
  parameter int STEP   = 3,
  parameter int RAMP   = 1,
  localparam int LW    = $clog2(LEVELS + 1)
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iSOF,
  input  logic                 iVAL,
  input  logic [DW-1:0]        iR,
  input  logic [DW-1:0]        iG,
  input  logic [DW-1:0]        iB,
  input  logic                 iEN,
  input  logic                 iWARM,
  input  logic [LW-1:0]        iLVL,
  output logic [DW-1:0]        oR,
  output logic [DW-1:0]        oG,
  output logic [DW-1:0]        oB,
  output logic                 oVAL,
  output logic                 oSOF,
  output logic signed [LW:0]   oLVL,
  output logic                 oBUSY
);

  localparam int OW = DW + 2;
  localparam int SW = DW + 3;
  localparam logic [SW-1:0] PIX_MAX = {3'b000, {DW{1'b1}}};
  localparam logic signed [LW:0] ONE = (LW + 1)'(1);

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] x, input logic [SW-1:0] d);
    logic [SW-1:0] s;
    s = SW'(x) + d;
    return (s > PIX_MAX) ? PIX_MAX[DW-1:0] : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] x, input logic [SW-1:0] d);
    logic [SW-1:0] s;
    s = SW'(x) - d;
    return (d >= SW'(x)) ? '0 : s[DW-1:0];
  endfunction

  logic [LW-1:0]        mag;
  logic signed [LW:0]   tgt;
  logic signed [LW:0]   cur_q, cur_d;
  logic                 busy_q, busy_d;
  logic [LW:0]          abs_cur;

  logic                 vld_p1_q, vld_p1_d, sof_p1_q, sof_p1_d;
  logic                 pos_p1_q, pos_p1_d, neg_p1_q, neg_p1_d;
  logic [DW-1:0]        r_p1_q, r_p1_d, g_p1_q, g_p1_d, b_p1_q, b_p1_d;
  logic [OW-1:0]        off_p1_q, off_p1_d;

  logic                 vld_p2_q, vld_p2_d, sof_p2_q, sof_p2_d;
  logic [DW-1:0]        r_p2_q, r_p2_d, g_p2_q, g_p2_d, b_p2_q, b_p2_d;
  logic [SW-1:0]        off1, off2;

  // Level control: target sampled every cycle, current level only moves on iSOF
  always_comb begin
    mag = (iLVL > LW'(LEVELS)) ? LW'(LEVELS) : iLVL;
    if (!iEN)       tgt = '0;
    else if (iWARM) tgt = $signed({1'b0, mag});
    else            tgt = -$signed({1'b0, mag});

    cur_d = cur_q;
    if (iSOF) begin
      if (RAMP != 0) begin
        if (tgt > cur_q)      cur_d = cur_q + ONE;
        else if (tgt < cur_q) cur_d = cur_q - ONE;
      end else begin
        cur_d = tgt;
      end
    end
    busy_d = (cur_d != tgt);
  end

  // Stage 1: capture pixel with the level in force before any same-cycle iSOF
  always_comb begin
    abs_cur  = cur_q[LW] ? $unsigned(-cur_q) : $unsigned(cur_q);
    vld_p1_d = iVAL;
    sof_p1_d = iSOF;
    r_p1_d   = r_p1_q;
    g_p1_d   = g_p1_q;
    b_p1_d   = b_p1_q;
    pos_p1_d = pos_p1_q;
    neg_p1_d = neg_p1_q;
    off_p1_d = off_p1_q;
    if (iVAL) begin
      r_p1_d   = iR;
      g_p1_d   = iG;
      b_p1_d   = iB;
      pos_p1_d = (cur_q > 0);
      neg_p1_d = cur_q[LW];
      off_p1_d = OW'(abs_cur) * OW'(STEP);
    end
  end

  // Stage 2: saturating offset; outputs hold between valid pixels
  always_comb begin
    off1     = SW'(off_p1_q);
    off2     = {off_p1_q, 1'b0};
    vld_p2_d = vld_p1_q;
    sof_p2_d = sof_p1_q;
    r_p2_d   = r_p2_q;
    g_p2_d   = g_p2_q;
    b_p2_d   = b_p2_q;
    if (vld_p1_q) begin
      if (pos_p1_q) begin
        r_p2_d = sat_add(r_p1_q, off1);
        g_p2_d = sat_add(g_p1_q, off1);
        b_p2_d = sat_sub(b_p1_q, off2);
      end else if (neg_p1_q) begin
        r_p2_d = sat_sub(r_p1_q, off1);
        g_p2_d = sat_sub(g_p1_q, off1);
        b_p2_d = sat_add(b_p1_q, off2);
      end else begin
        r_p2_d = r_p1_q;
        g_p2_d = g_p1_q;
        b_p2_d = b_p1_q;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cur_q    <= '0;
      busy_q   <= 1'b0;
      vld_p1_q <= 1'b0;
      sof_p1_q <= 1'b0;
      pos_p1_q <= 1'b0;
      neg_p1_q <= 1'b0;
      r_p1_q   <= '0;
      g_p1_q   <= '0;
      b_p1_q   <= '0;
      off_p1_q <= '0;
      vld_p2_q <= 1'b0;
      sof_p2_q <= 1'b0;
      r_p2_q   <= '0;
      g_p2_q   <= '0;
      b_p2_q   <= '0;
    end else begin
      cur_q    <= cur_d;
      busy_q   <= busy_d;
      vld_p1_q <= vld_p1_d;
      sof_p1_q <= sof_p1_d;
      pos_p1_q <= pos_p1_d;
      neg_p1_q <= neg_p1_d;
      r_p1_q   <= r_p1_d;
      g_p1_q   <= g_p1_d;
      b_p1_q   <= b_p1_d;
      off_p1_q <= off_p1_d;
      vld_p2_q <= vld_p2_d;
      sof_p2_q <= sof_p2_d;
      r_p2_q   <= r_p2_d;
      g_p2_q   <= g_p2_d;
      b_p2_q   <= b_p2_d;
    end
  end

  assign oR    = r_p2_q;
  assign oG    = g_p2_q;
  assign oB    = b_p2_q;
  assign oVAL  = vld_p2_q;
  assign oSOF  = sof_p2_q;
  assign oLVL  = cur_q;
  assign oBUSY = busy_q;

endmodule
